// File: rtl/conv_pe_array_param.sv
// Valid-mode 2-D convolution of an IN_H x IN_W ifmap with a K x K filter.
// The ifmap, the filter and relu_en are latched at start. K signed multipliers
// (one per filter column) feed an ACC_W accumulator over K cycles per output pixel.
// Each pixel is then shifted right by FRAC, saturated to DATA_W, optionally passed
// through ReLU, and emitted over a valid/ready handshake.
// Ports: clk/rst (sync, active-high); start, relu_en, ifmap_in_flat, filter_in_flat in;
//        out_valid/out_ready/out_data/out_row/out_col result stream; busy, done status.
module conv_pe_array_param #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int IN_H   = 5,
  parameter int IN_W   = 5,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 0,
  localparam int OUT_H = IN_H - K + 1,
  localparam int OUT_W = IN_W - K + 1,
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       relu_en,
  input  logic [IN_H*IN_W*DATA_W-1:0] ifmap_in_flat,
  input  logic [K*K*DATA_W-1:0]      filter_in_flat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic [COL_W-1:0]           out_col,
  output logic                       busy,
  output logic                       done
);

  localparam int KR_W = (K > 1) ? $clog2(K) : 1;

  // Saturation bounds, held at accumulator width for a signed compare.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  if (ACC_W < 2*DATA_W + $clog2(K*K)) begin : g_acc_w_check
    $error("conv_pe_array_param: ACC_W too narrow for a K*K sum of products");
  end
  if (IN_H < K || IN_W < K) begin : g_dim_check
    $error("conv_pe_array_param: ifmap smaller than filter");
  end

  typedef enum logic [1:0] {IDLE, COMP, EMIT, DONE} state_t;
  state_t state, state_nxt;

  logic [IN_H*IN_W*DATA_W-1:0] ifmap_q;
  logic [K*K*DATA_W-1:0]       filter_q;
  logic                        relu_q;
  logic signed [ACC_W-1:0]     acc, row_sum, acc_sum, y_shift;
  logic [KR_W-1:0]             kr;
  logic [ROW_W-1:0]            r;
  logic [COL_W-1:0]            c;
  logic [DATA_W-1:0]           res;
  logic signed [DATA_W-1:0]    a, b;
  logic signed [2*DATA_W-1:0]  prod;
  logic                        last_tap, last_px;

  assign last_tap = (kr == KR_W'(K-1));
  assign last_px  = (r == ROW_W'(OUT_H-1)) && (c == COL_W'(OUT_W-1));

  // One filter row per cycle: K products of the current window row, summed.
  always_comb begin
    row_sum = '0;
    a       = '0;
    b       = '0;
    prod    = '0;
    for (int kc = 0; kc < K; kc++) begin
      a       = ifmap_q[((int'(r) + int'(kr))*IN_W + int'(c) + kc)*DATA_W +: DATA_W];
      b       = filter_q[(int'(kr)*K + kc)*DATA_W +: DATA_W];
      prod    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
      row_sum = row_sum + ACC_W'(prod);
    end
  end

  // Result formatting is applied to the sum that includes the final filter row,
  // so out_data is ready in the same edge that enters EMIT.
  always_comb begin
    acc_sum = acc + row_sum;
    y_shift = acc_sum >>> FRAC;
    if (y_shift > SAT_MAX)      res = MAX_D;
    else if (y_shift < SAT_MIN) res = MIN_D;
    else                        res = y_shift[DATA_W-1:0];
    if (relu_q && res[DATA_W-1]) res = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)     state_nxt = COMP;
      COMP: if (last_tap)  state_nxt = EMIT;
      EMIT: if (out_ready) state_nxt = last_px ? DONE : COMP;
      DONE:                state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Operand latches; their contents do not matter after reset, so they carry none.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ifmap_q  <= ifmap_in_flat;
      filter_q <= filter_in_flat;
      relu_q   <= relu_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      kr       <= '0;
      r        <= '0;
      c        <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          kr  <= '0;
          r   <= '0;
          c   <= '0;
        end
        COMP: begin
          acc <= acc_sum;
          if (last_tap) out_data <= res;
          else          kr       <= kr + KR_W'(1);
        end
        EMIT: if (out_ready && !last_px) begin
          acc <= '0;
          kr  <= '0;
          if (c == COL_W'(OUT_W-1)) begin
            c <= '0;
            r <= r + ROW_W'(1);
          end else begin
            c <= c + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_row   = r;
  assign out_col   = c;

endmodule

// File: tb/tb_conv_pe_array_param.sv
// Testbench for conv_pe_array_param: two instances (FRAC=0 and FRAC=8) share all inputs.
// Expected pixels are pushed into per-instance queues at the time of frame acceptance.
// Each instance has a monitor that compares every presented pixel against the head of its queue.
module tb_conv_pe_array_param;

  localparam logic [31:0] NO_PIXEL = 32'hDEAD_BEEF; // row field can never hold 0xDE

  logic clk = 1'b0;
  logic rst, start, relu_en, out_ready;
  logic [399:0] ifmap_flat;
  logic [143:0] filter_flat;
  logic signed [15:0] ifm [25];
  logic signed [15:0] flt [9];

  logic        v0, v1, busy0, busy1, done0, done1;
  logic [15:0] d0, d1;
  logic [1:0]  r0, r1, c0, c1;

  always #5 clk = ~clk;

  always_comb begin
    ifmap_flat  = '0;
    filter_flat = '0;
    for (int i = 0; i < 25; i++) ifmap_flat[i*16 +: 16] = ifm[i];
    for (int i = 0; i < 9; i++)  filter_flat[i*16 +: 16] = flt[i];
  end

  conv_pe_array_param #(.FRAC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .ifmap_in_flat(ifmap_flat), .filter_in_flat(filter_flat),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_row(r0), .out_col(c0),
    .busy(busy0), .done(done0)
  );

  conv_pe_array_param #(.FRAC(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .ifmap_in_flat(ifmap_flat), .filter_in_flat(filter_flat),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_row(r1), .out_col(c1),
    .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int pe_cnt = 0;
  int done_cnt = 0;
  int done_pe = 0;
  int acc_pe = 0;

  always @(posedge clk) pe_cnt++;

  always @(negedge clk) begin
    if (done0) begin
      done_cnt++;
      done_pe = pe_cnt;
    end
  end

  always @(negedge clk) begin
    if (!rst && v0) begin
      chk("dut0_pixel", {6'd0, r0, 6'd0, c0, d0}, (exp_q0.size() > 0) ? exp_q0[0] : NO_PIXEL);
      if (out_ready && exp_q0.size() > 0) void'(exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && v1) begin
      chk("dut1_pixel", {6'd0, r1, 6'd0, c1, d1}, (exp_q1.size() > 0) ? exp_q1[0] : NO_PIXEL);
      if (out_ready && exp_q1.size() > 0) void'(exp_q1.pop_front());
    end
  end

  function automatic logic [15:0] model_px(input int r, input int c, input int frac, input logic relu);
    longint acc = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        acc += longint'(ifm[(r+kr)*5 + c + kc]) * longint'(flt[kr*3 + kc]);
    acc = acc >>> frac;
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0)   acc = 0;
    return 16'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_q0.push_back({8'(r), 8'(c), model_px(r, c, 0, relu_en)});
        exp_q1.push_back({8'(r), 8'(c), model_px(r, c, 8, relu_en)});
      end
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_pe = pe_cnt;
  endtask

  // Returns at the falling edge inside the DONE cycle (or after the budget expires).
  task automatic wait_done_edge();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done0 && n < 200);
    chk("done_seen", {31'd0, done0}, 32'd1);
  endtask

  task automatic finish_frame(input int exp_len);
    wait_done_edge();
    tick();
    chk("frame_len", done_pe - acc_pe, exp_len);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    chk("busy_idle", {31'd0, busy0}, 32'd0);
    chk("done_pulse", {31'd0, done0}, 32'd0);
  endtask

  task automatic set_basic();
    for (int i = 0; i < 25; i++) ifm[i] = 16'(i);
    for (int i = 0; i < 9; i++)  flt[i] = 16'sd1;
  endtask

  task automatic set_const(input logic [15:0] iv, input logic [15:0] fv);
    for (int i = 0; i < 25; i++) ifm[i] = iv;
    for (int i = 0; i < 9; i++)  flt[i] = fv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    set_basic();
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_data", {16'd0, d0}, 32'd0);
    chk("rst_rowcol", {28'd0, r0, c0}, 32'd0);
    chk("rst_data1", {16'd0, d1}, 32'd0);

    // Basic frame
    start_frame();
    chk("busy_start", {31'd0, busy0}, 32'd1);
    finish_frame(36);

    // Backpressure on pixel (0,1)
    start_frame();
    repeat (7) tick();
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", {31'd0, v0}, 32'd1);
      chk("bp_data", {16'd0, d0}, 32'd63);
      chk("bp_col", {30'd0, c0}, 32'd1);
    end
    out_ready = 1'b1;
    finish_frame(41);

    // Saturation and ReLU
    set_const(16'h7FFF, 16'h7FFF);
    start_frame();
    finish_frame(36);
    set_const(16'h8000, 16'h7FFF);
    start_frame();
    finish_frame(36);
    relu_en = 1'b1;
    start_frame();
    finish_frame(36);
    relu_en = 1'b0;

    // Scaling
    for (int i = 0; i < 25; i++) ifm[i] = 16'(-(i*256));
    for (int i = 0; i < 9; i++)  flt[i] = 16'sd0;
    flt[4] = 16'sh0100;
    start_frame();
    finish_frame(36);

    // Reset during the 4th pixel's computation
    set_basic();
    start_frame();
    repeat (13) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    chk("abort_valid", {31'd0, v0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_busy1", {31'd0, busy1}, 32'd0);
    n_done = done_cnt;
    repeat (40) tick();
    chk("abort_no_done", done_cnt, n_done);
    start_frame();
    finish_frame(36);

    // Start pulses while busy (COMP, EMIT, DONE) with maps changing underneath
    set_basic();
    start_frame();
    tick(); tick();
    for (int i = 0; i < 25; i++) ifm[i] = 16'($urandom);
    for (int i = 0; i < 9; i++)  flt[i] = 16'($urandom);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done_edge();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_frame_len", done_pe - acc_pe, 36);
    chk("busy_q0_drained", exp_q0.size(), 0);
    chk("done_start_ignored", {31'd0, busy0}, 32'd0);
    start_frame();
    chk("restart_busy", {31'd0, busy0}, 32'd1);
    finish_frame(36);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
